bp_resolve_queue: RTL and testbench

In-order branch resolution queue sitting directly downstream of the gshare predictor. At prediction time it records each in-flight branch's PHT index, global-history snapshot and predicted direction. When execute resolves the oldest branch, it produces the single-entry PHT training update and, on a misprediction, a flush pulse with the repaired global history. It owns the only path by which the predictor's counters and GHR are trained.

---
 rtl/bp_pkg.sv | 14 +
 rtl/bp_resolve_queue_if.sv | 33 +++
 rtl/bp_resolve_fifo.sv | 58 +++++
 rtl/bp_resolve_queue.sv | 122 ++++++++++++
 tb/tb_bp_resolve_queue.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor constants and the resolve-queue entry layout.
// The gshare predictor imports the same widths so both sides agree on index/GHR size.
package bp_pkg;

  localparam int IDX_W = 8;
  localparam int GHR_W = IDX_W;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [GHR_W-1:0] ghr;
    logic             pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Predictor/execute-facing handshake of the resolve queue: allocation, resolution
// and the PHT/GHR training outputs.
interface bp_resolve_queue_if
  import bp_pkg::*;
#(
  parameter int IF_IDX_W = bp_pkg::IDX_W,
  parameter int IF_GHR_W = bp_pkg::GHR_W
);

  logic                alloc_valid;
  logic                alloc_ready;
  logic [31:0]         alloc_pc;
  logic [IF_GHR_W-1:0] alloc_ghr;
  logic                alloc_pred_taken;
  logic                res_valid;
  logic                res_taken;
  logic                upd_valid;
  logic [IF_IDX_W-1:0] upd_index;
  logic                upd_taken;
  logic                mp_valid;
  logic [IF_GHR_W-1:0] mp_ghr;

  modport master (
    output alloc_valid, alloc_pc, alloc_ghr, alloc_pred_taken, res_valid, res_taken,
    input  alloc_ready, upd_valid, upd_index, upd_taken, mp_valid, mp_ghr
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_ghr, alloc_pred_taken, res_valid, res_taken,
    output alloc_ready, upd_valid, upd_index, upd_taken, mp_valid, mp_ghr
  );

endinterface

// File: rtl/bp_resolve_fifo.sv
// Generic in-order storage with wrap-bit pointers; clear-all beats push.
module bp_resolve_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 17,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [W-1:0]  head_data,
  output logic [PW-1:0] occupancy,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [W-1:0]  mem_r [DEPTH];

  // Pointer update: clear returns both pointers to zero regardless of push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (push && !clear) begin
      mem_r[wr_ptr_r[PW-2:0]] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r[PW-2:0]];
  assign occupancy = wr_ptr_r - rd_ptr_r;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]) &&
                     (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]);

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order branch resolution queue: trains the PHT and repairs the GHR on mispredict.
// Optional statistics counters are built only when BP_RESOLVE_STATS_EN is defined.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = bp_pkg::IDX_W,
  parameter int GHR_W = bp_pkg::GHR_W,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  bp_resolve_queue_if.slave   bus,
  input  logic                flush,
  output logic [PW-1:0]       occupancy,
  output logic                res_err,
  output logic [31:0]         stat_resolved,
  output logic [31:0]         stat_mispred
);

  bp_entry_t         alloc_entry_s;
  bp_entry_t         head_s;
  logic              full_s;
  logic              empty_s;
  logic              res_fire_s;
  logic              mispred_s;
  logic              clear_s;
  logic              push_s;
  logic              pop_s;
  logic              upd_valid_r;
  logic [IDX_W-1:0]  upd_index_r;
  logic              upd_taken_r;
  logic              mp_valid_r;
  logic [GHR_W-1:0]  mp_ghr_r;
  logic              res_err_r;

  // Entry formation and queue control; a mispredict squashes all younger entries.
  always_comb begin
    alloc_entry_s.index = bus.alloc_pc[IDX_W-1:0] ^ bus.alloc_ghr;
    alloc_entry_s.ghr   = bus.alloc_ghr;
    alloc_entry_s.pred  = bus.alloc_pred_taken;
    res_fire_s          = bus.res_valid & ~empty_s;
    mispred_s           = res_fire_s & (bus.res_taken != head_s.pred);
    clear_s             = flush | mispred_s;
    push_s              = bus.alloc_valid & ~full_s & ~clear_s;
    pop_s               = res_fire_s & ~clear_s;
  end

  bp_resolve_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(bp_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (alloc_entry_s),
    .pop       (pop_s),
    .clear     (clear_s),
    .head_data (head_s),
    .occupancy (occupancy),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Registered training/repair pulses, one cycle after the resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid_r <= 1'b0;
      upd_index_r <= {IDX_W{1'b0}};
      upd_taken_r <= 1'b0;
      mp_valid_r  <= 1'b0;
      mp_ghr_r    <= {GHR_W{1'b0}};
      res_err_r   <= 1'b0;
    end else begin
      upd_valid_r <= res_fire_s;
      mp_valid_r  <= mispred_s;
      res_err_r   <= bus.res_valid & empty_s;
      if (res_fire_s) begin
        upd_index_r <= head_s.index;
        upd_taken_r <= bus.res_taken;
      end
      if (mispred_s) begin
        mp_ghr_r <= (head_s.ghr << 1) | GHR_W'(bus.res_taken);
      end
    end
  end

  assign bus.alloc_ready = ~full_s;
  assign bus.upd_valid   = upd_valid_r;
  assign bus.upd_index   = upd_index_r;
  assign bus.upd_taken   = upd_taken_r;
  assign bus.mp_valid    = mp_valid_r;
  assign bus.mp_ghr      = mp_ghr_r;
  assign res_err         = res_err_r;

`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_r;
  logic [31:0] stat_mispred_r;

  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_resolved_r <= 32'd0;
      stat_mispred_r  <= 32'd0;
    end else begin
      if (res_fire_s) begin
        stat_resolved_r <= stat_resolved_r + 32'd1;
      end
      if (mispred_s) begin
        stat_mispred_r <= stat_mispred_r + 32'd1;
      end
    end
  end

  assign stat_resolved = stat_resolved_r;
  assign stat_mispred  = stat_mispred_r;
`else
  assign stat_resolved = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed self-checking bench for bp_resolve_queue.
module tb_bp_resolve_queue;
  import bp_pkg::*;

`ifdef BP_RESOLVE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  occupancy;
  logic        res_err;
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
  int          total = 0;
  int          bad   = 0;

  bp_resolve_queue_if bus ();

  bp_resolve_queue #(.DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .flush         (flush),
    .occupancy     (occupancy),
    .res_err       (res_err),
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid      = 1'b0;
    bus.alloc_pc         = 32'd0;
    bus.alloc_ghr        = 8'd0;
    bus.alloc_pred_taken = 1'b0;
    bus.res_valid        = 1'b0;
    bus.res_taken        = 1'b0;
    flush                = 1'b0;
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic [7:0] ghr, input logic pred);
    bus.alloc_valid      = 1'b1;
    bus.alloc_pc         = pc;
    bus.alloc_ghr        = ghr;
    bus.alloc_pred_taken = pred;
    tick();
    idle();
  endtask

  task automatic resolve1(input logic taken);
    bus.res_valid = 1'b1;
    bus.res_taken = taken;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check("rst_occ", occupancy, 4'd0);
    check("rst_ready", bus.alloc_ready, 1'b1);
    check("rst_upd_valid", bus.upd_valid, 1'b0);
    check("rst_upd_index", bus.upd_index, 8'h00);
    check("rst_upd_taken", bus.upd_taken, 1'b0);
    check("rst_mp_valid", bus.mp_valid, 1'b0);
    check("rst_mp_ghr", bus.mp_ghr, 8'h00);
    check("rst_res_err", res_err, 1'b0);
    check("rst_stat_res", stat_resolved, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // correct resolve: index = 0x13 ^ 0x05
    alloc1(32'h0000_0013, 8'h05, 1'b1);
    check("t1_occ1", occupancy, 4'd1);
    resolve1(1'b1);
    check("t1_upd_valid", bus.upd_valid, 1'b1);
    check("t1_upd_index", bus.upd_index, 8'h16);
    check("t1_upd_taken", bus.upd_taken, 1'b1);
    check("t1_mp_valid", bus.mp_valid, 1'b0);
    check("t1_occ0", occupancy, 4'd0);
    tick();
    check("t1_upd_pulse", bus.upd_valid, 1'b0);

    // mispredict with three younger entries
    alloc1(32'h0000_0013, 8'h05, 1'b1);
    alloc1(32'h0000_0020, 8'h01, 1'b0);
    alloc1(32'h0000_0021, 8'h02, 1'b1);
    alloc1(32'h0000_0022, 8'h03, 1'b0);
    check("t2_occ4", occupancy, 4'd4);
    resolve1(1'b0);
    check("t2_mp_valid", bus.mp_valid, 1'b1);
    check("t2_mp_ghr", bus.mp_ghr, 8'h0A);
    check("t2_upd_taken", bus.upd_taken, 1'b0);
    check("t2_upd_index", bus.upd_index, 8'h16);
    check("t2_occ0", occupancy, 4'd0);
    tick();
    check("t2_mp_pulse", bus.mp_valid, 1'b0);

    // fill to full, then reject further allocs
    for (int i = 0; i < 8; i++) alloc1(32'h40 + i, 8'h00, 1'b1);
    check("t3_occ8", occupancy, 4'd8);
    check("t3_ready0", bus.alloc_ready, 1'b0);
    alloc1(32'h0000_00AA, 8'h00, 1'b1);
    check("t3_occ8_rej", occupancy, 4'd8);
    bus.alloc_valid      = 1'b1;
    bus.alloc_pc         = 32'h0000_00BB;
    bus.alloc_pred_taken = 1'b1;
    bus.res_valid        = 1'b1;
    bus.res_taken        = 1'b1;
    tick();
    idle();
    check("t3_full_pop_idx", bus.upd_index, 8'h40);
    check("t3_full_pop_occ", occupancy, 4'd7);
    check("t3_ready1", bus.alloc_ready, 1'b1);
    for (int i = 1; i < 8; i++) begin
      resolve1(1'b1);
      check("t3_drain_idx", bus.upd_index, 8'h40 + 8'(i));
    end
    check("t3_drained", occupancy, 4'd0);

    // wrap-around: sustained alloc+resolve every cycle
    alloc1(32'h0000_007F, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.alloc_valid      = 1'b1;
      bus.alloc_pc         = 32'h80 + i;
      bus.alloc_ghr        = 8'h00;
      bus.alloc_pred_taken = 1'b1;
      bus.res_valid        = 1'b1;
      bus.res_taken        = 1'b1;
      tick();
      idle();
      check("t3_wrap_idx", bus.upd_index, (i == 0) ? 8'h7F : 8'h80 + 8'(i - 1));
      check("t3_wrap_occ", occupancy, 4'd1);
    end
    resolve1(1'b1);
    check("t3_wrap_last", bus.upd_index, 8'h93);
    check("t3_wrap_occ0", occupancy, 4'd0);

    // resolve with empty queue
    resolve1(1'b1);
    check("t4_res_err", res_err, 1'b1);
    check("t4_no_upd", bus.upd_valid, 1'b0);
    tick();
    check("t4_res_err_pulse", res_err, 1'b0);

    // flush + alloc + correct resolve
    alloc1(32'h0000_0013, 8'h05, 1'b1);
    flush                = 1'b1;
    bus.alloc_valid      = 1'b1;
    bus.alloc_pc         = 32'h0000_0055;
    bus.alloc_pred_taken = 1'b1;
    bus.res_valid        = 1'b1;
    bus.res_taken        = 1'b1;
    tick();
    idle();
    check("t5_upd_valid", bus.upd_valid, 1'b1);
    check("t5_upd_index", bus.upd_index, 8'h16);
    check("t5_mp_valid", bus.mp_valid, 1'b0);
    check("t5_occ0", occupancy, 4'd0);

    // flush coincident with mispredict: a single mp pulse
    alloc1(32'h0000_0013, 8'h05, 1'b1);
    flush         = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b0;
    tick();
    idle();
    check("t6_mp_valid", bus.mp_valid, 1'b1);
    check("t6_mp_ghr", bus.mp_ghr, 8'h0A);
    tick();
    check("t6_mp_once", bus.mp_valid, 1'b0);

    // asynchronous reset mid-burst
    alloc1(32'h0000_0031, 8'h00, 1'b1);
    alloc1(32'h0000_0032, 8'h00, 1'b1);
    alloc1(32'h0000_0033, 8'h00, 1'b1);
    resolve1(1'b1);
    check("t7_pre_upd", bus.upd_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t7_occ", occupancy, 4'd0);
    check("t7_ready", bus.alloc_ready, 1'b1);
    check("t7_upd_valid", bus.upd_valid, 1'b0);
    check("t7_upd_index", bus.upd_index, 8'h00);
    check("t7_stat_res", stat_resolved, 32'd0);
    check("t7_stat_mp", stat_mispred, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ten mispredicts then one correct resolve
    for (int i = 0; i < 10; i++) begin
      alloc1(32'h0000_0100 + i, 8'h00, 1'b1);
      resolve1(1'b0);
    end
    alloc1(32'h0000_0200, 8'h00, 1'b0);
    resolve1(1'b0);
    check("t8_stat_res", stat_resolved, STATS_EN ? 32'd11 : 32'd0);
    check("t8_stat_mp", stat_mispred, STATS_EN ? 32'd10 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
